// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcodes and the decoded-op record passed
// from the decoder to the issue buffer.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_XOR  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1111;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [3:0]      op;
      logic [XLEN-1:0] opnd1;
      logic [XLEN-1:0] opnd2;
      logic [4:0]      rd;
      logic            illegal;
   } dec_op_t;

   // Returns {illegal, op} for the shared R/I funct3 map; SUB only when allowed.
   function automatic logic [4:0] map_arith(input logic [2:0] f3,
                                            input logic       allow_sub,
                                            input logic       b5);
      logic [4:0] res;
      case (f3)
         3'b000:  res = {1'b0, (allow_sub && b5) ? ALU_SUB : ALU_ADD};
         3'b001:  res = {1'b0, ALU_SLL};
         3'b011:  res = {1'b0, ALU_SLTU};
         3'b100:  res = {1'b0, ALU_XOR};
         3'b101:  res = {1'b0, b5 ? ALU_SRA : ALU_SRL};
         3'b110:  res = {1'b0, ALU_OR};
         3'b111:  res = {1'b0, ALU_AND};
         default: res = {1'b1, ALU_AND};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I field decode into ALU op code and operand selection.
// Illegal ops keep rs1/rs2 as operands and report op AND with the illegal flag.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [6:0]      i_opcode,
   input  logic [2:0]      i_funct3,
   input  logic            i_funct7b5,
   input  logic [4:0]      i_rd,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [XLEN-1:0] i_imm,
   input  logic [XLEN-1:0] i_pc,
   output dec_op_t         o_dec
);

   logic [4:0] w_arith;
   dec_op_t    w_dec;

   always_comb begin
      w_arith       = 5'b0;
      w_dec.op      = ALU_AND;
      w_dec.opnd1   = i_rs1;
      w_dec.opnd2   = i_rs2;
      w_dec.rd      = i_rd;
      w_dec.illegal = 1'b1;
      case (i_opcode)
         OPC_R: begin
            w_arith       = map_arith(i_funct3, 1'b1, i_funct7b5);
            w_dec.op      = w_arith[3:0];
            w_dec.illegal = w_arith[4];
         end
         OPC_I: begin
            w_arith       = map_arith(i_funct3, 1'b0, i_funct7b5);
            w_dec.op      = w_arith[3:0];
            w_dec.illegal = w_arith[4];
            if (!w_arith[4]) begin
               // Shift-immediates use only the shamt field.
               if (i_funct3 == 3'b001 || i_funct3 == 3'b101)
                  w_dec.opnd2 = {{(XLEN-5){1'b0}}, i_imm[4:0]};
               else
                  w_dec.opnd2 = i_imm;
            end
         end
         OPC_LOAD, OPC_STORE: begin
            w_dec.op      = ALU_ADD;
            w_dec.opnd2   = i_imm;
            w_dec.illegal = 1'b0;
         end
         OPC_LUI: begin
            w_dec.op      = ALU_ADD;
            w_dec.opnd1   = '0;
            w_dec.opnd2   = i_imm;
            w_dec.illegal = 1'b0;
         end
         OPC_AUIPC: begin
            w_dec.op      = ALU_ADD;
            w_dec.opnd1   = i_pc;
            w_dec.opnd2   = i_imm;
            w_dec.illegal = 1'b0;
         end
         OPC_BRANCH: begin
            case (i_funct3)
               3'b000, 3'b001: begin
                  w_dec.op      = ALU_SUB;
                  w_dec.illegal = 1'b0;
               end
               3'b110, 3'b111: begin
                  w_dec.op      = ALU_SLTU;
                  w_dec.illegal = 1'b0;
               end
               default: w_dec.illegal = 1'b1;
            endcase
         end
         default: w_dec.illegal = 1'b1;
      endcase
   end

   assign o_dec = w_dec;

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decoded op held in a main register backed by one skid
// entry, valid/ready on both sides, flush, and an issue counter.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN  = alu_pkg::XLEN,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [2:0]       in_funct3,
   input  logic             in_funct7b5,
   input  logic [4:0]       in_rd,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       alu_op,
   output logic [XLEN-1:0]  alu_operand1,
   output logic [XLEN-1:0]  alu_operand2,
   output logic [4:0]       out_rd,
   output logic             out_illegal,
   output logic [CNT_W-1:0] issue_count
);

   dec_op_t          w_dec;
   dec_op_t          r_main;
   dec_op_t          r_skid;
   logic             r_main_valid;
   logic             r_skid_valid;
   logic [CNT_W-1:0] r_count;
   logic             w_accept;
   logic             w_drain;

   alu_op_decode u_decode (
      .i_opcode   (in_opcode),
      .i_funct3   (in_funct3),
      .i_funct7b5 (in_funct7b5),
      .i_rd       (in_rd),
      .i_rs1      (in_rs1),
      .i_rs2      (in_rs2),
      .i_imm      (in_imm),
      .i_pc       (in_pc),
      .o_dec      (w_dec)
   );

   // in_ready depends only on skid state, so there is no path from out_ready.
   assign w_accept = in_valid && !r_skid_valid;
   assign w_drain  = r_main_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_count      <= '0;
      end else begin
         if (w_drain)
            r_count <= r_count + 1'b1;
         if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
         end else if (w_drain) begin
            if (r_skid_valid) begin
               r_main       <= r_skid;
               r_skid_valid <= 1'b0;
            end else if (w_accept) begin
               r_main <= w_dec;
            end else begin
               r_main_valid <= 1'b0;
            end
         end else if (!r_main_valid) begin
            if (w_accept) begin
               r_main       <= w_dec;
               r_main_valid <= 1'b1;
            end
         end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
         end
      end
   end

   assign in_ready     = !r_skid_valid;
   assign out_valid    = r_main_valid;
   assign alu_op       = r_main.op;
   assign alu_operand1 = r_main.opnd1;
   assign alu_operand2 = r_main.opnd2;
   assign out_rd       = r_main.rd;
   assign out_illegal  = r_main.illegal;
   assign issue_count  = r_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure, streaming,
// flush and asynchronous reset, with a 4-bit counter so wrap is reachable.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_funct7b5;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd, out_rd;
   logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
   logic        out_valid, out_ready, out_illegal;
   logic [3:0]  alu_op;
   logic [31:0] alu_operand1, alu_operand2;
   logic [3:0]  issue_count;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(32), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_funct3    (in_funct3),
      .in_funct7b5  (in_funct7b5),
      .in_rd        (in_rd),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .in_imm       (in_imm),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .alu_op       (alu_op),
      .alu_operand1 (alu_operand1),
      .alu_operand2 (alu_operand2),
      .out_rd       (out_rd),
      .out_illegal  (out_illegal),
      .issue_count  (issue_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                        input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc);
      in_valid    = 1'b1;
      in_opcode   = op;
      in_funct3   = f3;
      in_funct7b5 = b5;
      in_rd       = rd;
      in_rs1      = rs1;
      in_rs2      = rs2;
      in_imm      = imm;
      in_pc       = pc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  sent, rcv, cyc;
      logic hs_in, hs_out;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(7'd0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      in_valid = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_op1", alu_operand1, 32'd0);
      chk("rst_op2", alu_operand2, 32'd0);
      chk("rst_rd", 32'(out_rd), 32'd0);
      chk("rst_illegal", 32'(out_illegal), 32'd0);
      chk("rst_count", 32'(issue_count), 32'd0);

      // Decode vectors back to back, out_ready held high.
      out_ready = 1'b1;
      drive(7'b0110011, 3'b000, 1'b0, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0);
      step();
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_op", 32'(alu_op), 32'b0010);
      chk("add_op1", alu_operand1, 32'd5);
      chk("add_op2", alu_operand2, 32'd7);
      chk("add_rd", 32'(out_rd), 32'd3);
      drive(7'b0110011, 3'b000, 1'b1, 5'd4, 32'd9, 32'd4, 32'd0, 32'd0);
      step(); exp_cnt++;
      chk("sub_op", 32'(alu_op), 32'b0110);
      chk("sub_op1", alu_operand1, 32'd9);
      chk("cnt_1", 32'(issue_count), 32'(exp_cnt % 16));
      drive(7'b0010011, 3'b101, 1'b1, 5'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0403, 32'd0);
      step(); exp_cnt++;
      chk("srai_op", 32'(alu_op), 32'b1001);
      chk("srai_op1", alu_operand1, 32'h8000_0000);
      chk("srai_op2", alu_operand2, 32'd3);
      drive(7'b0110111, 3'b000, 1'b0, 5'd6, 32'hDEAD_BEEF, 32'd1, 32'h1234_5000, 32'd0);
      step(); exp_cnt++;
      chk("lui_op", 32'(alu_op), 32'b0010);
      chk("lui_op1", alu_operand1, 32'd0);
      chk("lui_op2", alu_operand2, 32'h1234_5000);
      drive(7'b0010111, 3'b000, 1'b0, 5'd7, 32'd77, 32'd1, 32'h20, 32'h100);
      step(); exp_cnt++;
      chk("auipc_op1", alu_operand1, 32'h100);
      chk("auipc_op2", alu_operand2, 32'h20);
      drive(7'b1111111, 3'b000, 1'b0, 5'd8, 32'h11, 32'h22, 32'h33, 32'd0);
      step(); exp_cnt++;
      chk("ill_opc_flag", 32'(out_illegal), 32'd1);
      chk("ill_opc_op", 32'(alu_op), 32'd0);
      chk("ill_opc_op1", alu_operand1, 32'h11);
      chk("ill_opc_op2", alu_operand2, 32'h22);
      drive(7'b0110011, 3'b010, 1'b0, 5'd9, 32'h44, 32'h55, 32'd0, 32'd0);
      step(); exp_cnt++;
      chk("ill_slt_flag", 32'(out_illegal), 32'd1);
      chk("ill_slt_op", 32'(alu_op), 32'd0);
      drive(7'b1100011, 3'b110, 1'b0, 5'd10, 32'h66, 32'h77, 32'd0, 32'd0);
      step(); exp_cnt++;
      chk("bltu_op", 32'(alu_op), 32'b1111);
      chk("bltu_flag", 32'(out_illegal), 32'd0);
      chk("bltu_op2", alu_operand2, 32'h77);
      in_valid = 1'b0;
      step(); exp_cnt++;
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("cnt_8", 32'(issue_count), 32'(exp_cnt % 16));

      // Backpressure: A in main, B in skid, hold, then drain in order.
      out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 1'b0, 5'd1, 32'd1, 32'd2, 32'd0, 32'd0);
      step();
      chk("bp_a_ready", 32'(in_ready), 32'd1);
      drive(7'b0110011, 3'b100, 1'b0, 5'd2, 32'd3, 32'd4, 32'd0, 32'd0);
      step();
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_op1", alu_operand1, 32'd1);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         step();
      end
      out_ready = 1'b1;
      step(); exp_cnt++;
      chk("bp_b_op", 32'(alu_op), 32'b1010);
      chk("bp_b_op1", alu_operand1, 32'd3);
      chk("bp_b_rd", 32'(out_rd), 32'd2);
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      step(); exp_cnt++;
      chk("bp_empty", 32'(out_valid), 32'd0);
      chk("cnt_10", 32'(issue_count), 32'(exp_cnt % 16));

      // Stream 10 ops with out_ready toggling; counter wraps past 15.
      sent = 0; rcv = 0; cyc = 0;
      while (rcv < 10 && cyc < 80) begin
         out_ready = (cyc % 2 == 0);
         if (sent < 10)
            drive(7'b0110011, 3'b000, 1'b0, 5'(sent), 32'(sent + 100), 32'd0, 32'd0, 32'd0);
         else
            in_valid = 1'b0;
         hs_in  = in_valid && in_ready;
         hs_out = out_valid && out_ready;
         if (hs_out) begin
            chk("stream_op1", alu_operand1, 32'(rcv + 100));
            rcv++;
         end
         step();
         if (hs_in) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      exp_cnt += 10;
      chk("stream_all_out", 32'(rcv), 32'd10);
      chk("cnt_wrap", 32'(issue_count), 32'(exp_cnt % 16));

      // Flush with main and skid full plus a new offer.
      out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 1'b0, 5'd1, 32'hA1, 32'd0, 32'd0, 32'd0);
      step();
      drive(7'b0110011, 3'b000, 1'b0, 5'd2, 32'hB2, 32'd0, 32'd0, 32'd0);
      step();
      chk("fl_full", 32'(in_ready), 32'd0);
      drive(7'b0110011, 3'b000, 1'b0, 5'd3, 32'hC3, 32'd0, 32'd0, 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fl_nothing", 32'(out_valid), 32'd0);
      end
      chk("fl_cnt", 32'(issue_count), 32'(exp_cnt % 16));

      // Drain coinciding with flush still counts.
      out_ready = 1'b0;
      drive(7'b0110011, 3'b000, 1'b0, 5'd4, 32'hD4, 32'd0, 32'd0, 32'd0);
      step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      flush = 1'b1;
      step(); exp_cnt++;
      flush = 1'b0;
      chk("fl_drain_valid", 32'(out_valid), 32'd0);
      chk("fl_drain_cnt", 32'(issue_count), 32'(exp_cnt % 16));

      // Asynchronous reset in the middle of a cycle with the buffer full.
      out_ready = 1'b0;
      drive(7'b0110011, 3'b111, 1'b0, 5'd5, 32'hE5, 32'hE6, 32'd0, 32'd0);
      step();
      drive(7'b0110011, 3'b110, 1'b0, 5'd6, 32'hF6, 32'hF7, 32'd0, 32'd0);
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      chk("arst_op", 32'(alu_op), 32'd0);
      chk("arst_op1", alu_operand1, 32'd0);
      chk("arst_op2", alu_operand2, 32'd0);
      chk("arst_rd", 32'(out_rd), 32'd0);
      chk("arst_cnt", 32'(issue_count), 32'd0);
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("arst_after", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
